// File: rtl/piece_offset_ctrl_pkg.sv
// Shared constants and types for the piece offset controller.
// Colour values match those used by the display path.
package piece_offset_ctrl_pkg;

  localparam int PIECE_STEP  = 32;
  localparam int PIECE_X_MIN = -96;
  localparam int PIECE_X_MAX = 160;
  localparam int PIECE_Y_MIN = -256;
  localparam int PIECE_Y_MAX = 0;

  localparam logic [2:0] COLOR_RED  = 3'b100;
  localparam logic [2:0] COLOR_BLUE = 3'b001;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

endpackage

// File: rtl/piece_offset_ctrl_button_conditioner.sv
// One push-button: 2-FF synchroniser, stability debounce,
// debounced level and one-cycle press pulse on its rising edge.
module piece_offset_ctrl_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iBtn,
  output logic oLevel,
  output logic oPress
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      cnt    <= '0;
      oLevel <= 1'b0;
      oPress <= 1'b0;
    end else begin
      meta   <= iBtn;
      sync   <= meta;
      oPress <= 1'b0;
      if (sync == oLevel) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        oLevel <= sync;
        oPress <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/piece_offset_ctrl.sv
// Button-driven piece offset/colour, updated only on iFrameTick.
// Define PIECE_AUTOREPEAT_EN to build per-direction auto-repeat.
module piece_offset_ctrl
  import piece_offset_ctrl_pkg::*;
#(
  parameter int         STEP            = PIECE_STEP,
  parameter int         X_MIN           = PIECE_X_MIN,
  parameter int         X_MAX           = PIECE_X_MAX,
  parameter int         Y_MIN           = PIECE_Y_MIN,
  parameter int         Y_MAX           = PIECE_Y_MAX,
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         REPEAT_FRAMES   = 12,
  parameter int         FLASH_FRAMES    = 8,
  parameter logic [2:0] COLOR_NORMAL    = COLOR_RED,
  parameter logic [2:0] COLOR_BLOCKED   = COLOR_BLUE
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iBtnLeft,
  input  logic       iBtnRight,
  input  logic       iBtnUp,
  input  logic       iBtnDown,
  input  logic       iFrameTick,
  output logic [9:0] oXOffset,
  output logic [9:0] oYOffset,
  output logic [2:0] oColor
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] X_LO   = 11'(X_MIN);
  localparam logic signed [10:0] X_HI   = 11'(X_MAX);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX);

  logic [3:0]    btn;
  logic [3:0]    lvl;
  logic [3:0]    press;
  logic [3:0]    rep_set;
  logic [3:0]    pend;
  logic [3:0]    pend_n;
  logic [FW-1:0] flash;

  logic signed [10:0] x_ext, x_cand;
  logic signed [10:0] y_ext, y_cand;
  logic x_mv, x_ok, y_mv, y_ok, blk;

  assign btn = {iBtnDown, iBtnUp, iBtnRight, iBtnLeft};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    piece_offset_ctrl_button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .Clock (Clock),
      .Reset (Reset),
      .iBtn  (btn[g]),
      .oLevel(lvl[g]),
      .oPress(press[g])
    );
  end

`ifdef PIECE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);

  logic [RW-1:0] rep_cnt [4];

  for (genvar g = 0; g < 4; g++) begin : g_rep
    assign rep_set[g] = lvl[g] & iFrameTick
                      & (rep_cnt[g] == REP_LAST);

    always_ff @(posedge Clock) begin
      if (Reset || !lvl[g]) begin
        rep_cnt[g] <= '0;
      end else if (iFrameTick) begin
        if (rep_cnt[g] == REP_LAST) rep_cnt[g] <= '0;
        else rep_cnt[g] <= rep_cnt[g] + 1'b1;
      end
    end
  end
`else
  assign rep_set = '0;
`endif

  // A new request in the tick cycle survives; the tick consumes the old flags.
  always_comb begin
    pend_n = ((press & lvl) | rep_set)
           | (iFrameTick ? 4'b0000 : pend);
  end

  always_comb begin
    x_ext  = {oXOffset[9], oXOffset};
    y_ext  = {oYOffset[9], oYOffset};
    x_mv   = pend[DIR_LEFT] ^ pend[DIR_RIGHT];
    y_mv   = pend[DIR_UP] ^ pend[DIR_DOWN];
    x_cand = pend[DIR_LEFT] ? x_ext - STEP_S : x_ext + STEP_S;
    y_cand = pend[DIR_UP] ? y_ext - STEP_S : y_ext + STEP_S;
    x_ok   = (x_cand >= X_LO) && (x_cand <= X_HI);
    y_ok   = (y_cand >= Y_LO) && (y_cand <= Y_HI);
    blk    = (x_mv & ~x_ok) | (y_mv & ~y_ok);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pend     <= '0;
      oXOffset <= '0;
      oYOffset <= '0;
      flash    <= '0;
    end else begin
      pend <= pend_n;
      if (iFrameTick) begin
        if (x_mv && x_ok) oXOffset <= x_cand[9:0];
        if (y_mv && y_ok) oYOffset <= y_cand[9:0];
        if (blk) flash <= FW'(FLASH_FRAMES);
        else if (flash != '0) flash <= flash - 1'b1;
      end
    end
  end

  assign oColor = (flash != '0) ? COLOR_BLOCKED : COLOR_NORMAL;

endmodule

// File: tb/tb_piece_offset_ctrl.sv
// Scoreboard bench for piece_offset_ctrl with a 4-cycle debounce.
// Expected offsets after each frame tick are queued by the stimulus.
module tb_piece_offset_ctrl;

  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] BLUE = 3'b001;
  localparam logic [3:0] BL = 4'b0001;
  localparam logic [3:0] BR = 4'b0010;
  localparam logic [3:0] BU = 4'b0100;
  localparam logic [3:0] BD = 4'b1000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
  logic       tick = 1'b0;
  logic       tick_d = 1'b0;
  logic [9:0] xo, yo;
  logic [2:0] col;

  typedef struct {
    string      name;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  piece_offset_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iBtnLeft  (bl),
    .iBtnRight (br),
    .iBtnUp    (bu),
    .iBtnDown  (bd),
    .iFrameTick(tick),
    .oXOffset  (xo),
    .oYOffset  (yo),
    .oColor    (col)
  );

  always #5 Clock = ~Clock;

  task automatic cmp(string n, logic [9:0] x, logic [9:0] y,
                     logic [2:0] c);
    checks++;
    if (xo !== x || yo !== y || col !== c) begin
      errors++;
      $display("FAIL %s: got x=%h y=%h c=%b, want x=%h y=%h c=%b",
               n, xo, yo, col, x, y, c);
    end
  endtask

  always @(posedge Clock) tick_d <= tick;

  always @(negedge Clock) begin
    exp_t e;
    if (tick_d) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got no queued entry, want one");
      end else begin
        e = sb.pop_front();
        cmp(e.name, e.x, e.y, e.c);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic set_btns(logic [3:0] m);
    {bd, bu, br, bl} = m;
  endtask

  task automatic press(logic [3:0] m);
    set_btns(m);
    step(10);
    set_btns(4'b0000);
    step(10);
  endtask

  task automatic do_tick(string n, logic [9:0] x, logic [9:0] y,
                         logic [2:0] c);
    exp_t e;
    e.name = n;
    e.x = x;
    e.y = y;
    e.c = c;
    sb.push_back(e);
    tick = 1'b1;
    @(negedge Clock);
    tick = 1'b0;
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
  endtask

  initial begin
    step(3);
    Reset = 1'b0;
    step(1);
    cmp("reset", 10'h000, 10'h000, RED);

    press(BR);
    do_tick("right_move", 10'd32, 10'h000, RED);

    set_btns(BL);
    step(2);
    set_btns(4'b0000);
    step(10);
    do_tick("glitch", 10'd32, 10'h000, RED);

    press(BL);
    do_tick("left_to_0", 10'h000, 10'h000, RED);
    press(BL);
    do_tick("left_m32", 10'h3E0, 10'h000, RED);
    press(BL);
    do_tick("left_m64", 10'h3C0, 10'h000, RED);
    press(BL);
    do_tick("left_m96", 10'h3A0, 10'h000, RED);
    press(BL);
    do_tick("left_block", 10'h3A0, 10'h000, BLUE);
    for (int i = 1; i < 8; i++)
      do_tick($sformatf("flash_%0d", i), 10'h3A0, 10'h000, BLUE);
    do_tick("flash_end", 10'h3A0, 10'h000, RED);

    press(BL | BR);
    do_tick("conflict", 10'h3A0, 10'h000, RED);

    set_btns(BR);
    step(6);
    do_tick("coincident_tick", 10'h3A0, 10'h000, RED);
    set_btns(4'b0000);
    step(10);
    do_tick("coincident_next", 10'h3C0, 10'h000, RED);

    set_btns(BU);
    step(10);
    for (int i = 0; i < 30; i++) begin
`ifdef PIECE_AUTOREPEAT_EN
      if (i < 12)
        do_tick($sformatf("repeat_%0d", i), 10'h3C0, 10'h3E0, RED);
      else if (i < 24)
        do_tick($sformatf("repeat_%0d", i), 10'h3C0, 10'h3C0, RED);
      else
        do_tick($sformatf("repeat_%0d", i), 10'h3C0, 10'h3A0, RED);
`else
      do_tick($sformatf("repeat_%0d", i), 10'h3C0, 10'h3E0, RED);
`endif
    end
    set_btns(4'b0000);
    step(10);

    set_btns(BR);
    step(10);
    set_btns(4'b0000);
    do_reset();
    step(1);
    cmp("reset_mid", 10'h000, 10'h000, RED);
    step(10);
    do_tick("pending_dropped", 10'h000, 10'h000, RED);

    set_btns(BU);
    step(2);
    do_reset();
    step(1);
    cmp("reset_held", 10'h000, 10'h000, RED);
    step(10);
    do_tick("held_repulse", 10'h000, 10'h3E0, RED);
    set_btns(4'b0000);
    step(10);

    press(BD);
    do_tick("down_to_0", 10'h000, 10'h000, RED);
    press(BD | BR);
    do_tick("block_y_move_x", 10'd32, 10'h000, BLUE);

    step(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
